// File: rtl/div_sched_pkg.sv
// Shared encodings for the divider scheduler: op codes, FSM states and the
// fixed corner-case results that bypass the divider.
package div_sched_pkg;

  localparam logic [1:0] OP_DIV_W  = 2'b00;
  localparam logic [1:0] OP_MOD_W  = 2'b01;
  localparam logic [1:0] OP_DIV_WU = 2'b10;
  localparam logic [1:0] OP_MOD_WU = 2'b11;

  localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/div_sched_if.sv
// Signal bundle between the two issue pipes, the scheduler and the shared div_alu.
// Handshakes: a transfer happens in a cycle where valid and ready are both high at the
// rising edge; reqN_ready is combinational, resp_valid is held until resp_ready or flush.
interface div_sched_if;
  import div_sched_pkg::*;

  logic        flush;
  logic        req0_valid;
  logic        req1_valid;
  logic [1:0]  req0_op;
  logic [1:0]  req1_op;
  logic [31:0] req0_a;
  logic [31:0] req1_a;
  logic [31:0] req0_b;
  logic [31:0] req1_b;
  logic        req0_ready;
  logic        req1_ready;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_dbz;
  logic        resp_ready;
  logic        busy;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_dbz;
  logic        div_done;
  state_e      dbg_state;

  modport slave (
    input  flush, req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
           resp_ready, div_quotient, div_remainder, div_dbz, div_done,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_dbz, busy,
           div_start, div_signed, div_dividend, div_divisor, dbg_state
  );

  modport master (
    output flush, req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
           resp_ready, div_quotient, div_remainder, div_dbz, div_done,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_dbz, busy,
           div_start, div_signed, div_dividend, div_divisor, dbg_state
  );

endinterface

// File: rtl/div_sched_arb.sv
// Two-way arbiter: on a tie the pipe not granted last wins (RR_EN=1), or pipe 0 always wins (RR_EN=0).
module div_sched_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic v0,
  input  logic v1,
  output logic g0,
  output logic g1
);

  logic last_grant;
  logic pick1;

  always_comb begin
    pick1 = 1'b0;
    if (v1 && !v0) begin
      pick1 = 1'b1;
    end else if (v0 && v1 && RR_EN && !last_grant) begin
      pick1 = 1'b1;
    end
    g0 = en && v0 && !pick1;
    g1 = en && v1 && pick1;
  end

  // Starts at 1 so that pipe 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (g0 || g1) begin
      last_grant <= g1;
    end
  end

endmodule

// File: rtl/div_sched.sv
// Shares one div_alu between two issue pipes: arbitrates, sequences start/done,
// resolves divide-by-zero and INT_MIN/-1 locally, and drains flushed operations.
module div_sched
  import div_sched_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  div_sched_if.slave bus
);

  state_e      state;
  state_e      state_nxt;
  logic        g0;
  logic        g1;
  logic        grant;
  logic        arb_en;
  logic        take_done;
  logic [1:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        signed_in;
  logic        zero_in;
  logic        ovf_in;
  logic        op_signed;
  logic        sel_rem;
  logic        id_q;
  logic        dbz_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        unused;

  // The divider's own dbz flag is redundant: zero divisors never reach it.
  assign unused = bus.div_dbz;

  assign arb_en = (state == S_IDLE) && !bus.flush;

  div_sched_arb #(.RR_EN(RR_EN)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .v0  (bus.req0_valid),
    .v1  (bus.req1_valid),
    .g0  (g0),
    .g1  (g1)
  );

  always_comb begin
    grant     = g0 || g1;
    op_in     = g1 ? bus.req1_op : bus.req0_op;
    a_in      = g1 ? bus.req1_a : bus.req0_a;
    b_in      = g1 ? bus.req1_b : bus.req0_b;
    signed_in = ~op_in[1];
    zero_in   = (b_in == 32'h0);
    ovf_in    = signed_in && (a_in == INT_MIN) && (b_in == DBZ_QUOT);
    take_done = (state == S_WAIT) && bus.div_done && !bus.flush;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = (zero_in || ovf_in) ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = bus.flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (bus.flush) begin
          state_nxt = bus.div_done ? S_IDLE : S_DRAIN;
        end else if (bus.div_done) begin
          state_nxt = S_RESP;
        end
      end
      S_DRAIN: if (bus.div_done) state_nxt = S_IDLE;
      S_RESP:  if (bus.flush || bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands only change on a grant in IDLE, so div_alu sees them stable until done.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_signed <= 1'b0;
      sel_rem   <= 1'b0;
      id_q      <= 1'b0;
      dbz_q     <= 1'b0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      res_q     <= 32'h0;
    end else if (grant) begin
      op_signed <= signed_in;
      sel_rem   <= op_in[0];
      id_q      <= g1;
      dbz_q     <= zero_in;
      a_q       <= a_in;
      b_q       <= b_in;
      if (zero_in) begin
        res_q <= op_in[0] ? a_in : DBZ_QUOT;
      end else if (ovf_in) begin
        res_q <= op_in[0] ? 32'h0 : INT_MIN;
      end
    end else if (take_done) begin
      res_q <= sel_rem ? bus.div_remainder : bus.div_quotient;
    end
  end

  assign bus.req0_ready   = g0;
  assign bus.req1_ready   = g1;
  assign bus.resp_valid   = (state == S_RESP) && !bus.flush;
  assign bus.resp_id      = id_q;
  assign bus.resp_data    = res_q;
  assign bus.resp_dbz     = dbz_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.div_start    = (state == S_ISSUE) && !bus.flush;
  assign bus.div_signed   = op_signed;
  assign bus.div_dividend = a_q;
  assign bus.div_divisor  = b_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: a behavioural div_alu with adjustable latency, a response
// scoreboard fed at request acceptance, and a second fixed-priority instance for RR_EN=0.
module tb_div_sched;
  import div_sched_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   lat;
  int   cnt;
  int   start_cnt;
  int   last_start_cyc;
  int   hs_cnt;
  int   drain_bad;
  state_e drain_st;
  logic [33:0] exp_q[$];

  div_sched_if b1();
  div_sched_if b0();

  div_sched #(.RR_EN(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(b1));
  div_sched #(.RR_EN(1'b0)) u_dut_fp (.clk(clk), .rst(rst), .bus(b0));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural div_alu ----------------
  logic [31:0] mq;
  logic [31:0] mr;

  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (b1.div_start) cnt <= lat;
    else if (cnt > 0) cnt <= cnt - 1;
  end

  always_comb begin
    mq = 32'hFFFF_FFFF;
    mr = b1.div_dividend;
    if (b1.div_divisor != 32'h0) begin
      if (b1.div_signed) begin
        if (b1.div_dividend == 32'h8000_0000 && b1.div_divisor == 32'hFFFF_FFFF) begin
          mq = 32'h8000_0000;
          mr = 32'h0;
        end else begin
          mq = $signed(b1.div_dividend) / $signed(b1.div_divisor);
          mr = $signed(b1.div_dividend) % $signed(b1.div_divisor);
        end
      end else begin
        mq = b1.div_dividend / b1.div_divisor;
        mr = b1.div_dividend % b1.div_divisor;
      end
    end
  end

  assign b1.div_done      = (cnt == 1);
  assign b1.div_quotient  = mq;
  assign b1.div_remainder = mr;
  assign b1.div_dbz       = (b1.div_divisor == 32'h0);

  assign b0.div_done      = 1'b0;
  assign b0.div_quotient  = 32'h0;
  assign b0.div_remainder = 32'h0;
  assign b0.div_dbz       = 1'b0;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [33:0] got;
  logic [33:0] want;

  always @(negedge clk) begin
    if (!rst) begin
      if (b1.div_start) begin
        start_cnt++;
        last_start_cyc = cyc;
      end
      if (b1.resp_valid && b1.resp_ready) begin
        hs_cnt++;
        got = {b1.resp_id, b1.resp_dbz, b1.resp_data};
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'(got), 64'h0);
        end else begin
          want = exp_q.pop_front();
          chk("resp", 64'(got), 64'(want));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int pipe, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (pipe == 0) begin
      b1.req0_valid = v; b1.req0_op = op; b1.req0_a = a; b1.req0_b = b;
    end else begin
      b1.req1_valid = v; b1.req1_op = op; b1.req1_a = a; b1.req1_b = b;
    end
  endtask

  task automatic send(input int pipe, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_data, input logic exp_dbz,
                      input bit push, output int acc);
    int n;
    n = 0;
    acc = -1;
    set_req(pipe, 1'b1, op, a, b);
    while (acc < 0 && n < 300) begin
      @(negedge clk);
      if ((pipe == 0 && b1.req0_ready) || (pipe != 0 && b1.req1_ready)) acc = cyc;
      n++;
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pipe %0d ready never seen, expected a grant", pipe);
    end else if (push) begin
      exp_q.push_back({pipe[0], exp_dbz, exp_data});
    end
    @(posedge clk);
    #1;
    set_req(pipe, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic wait_valid(output int c);
    c = -1;
    for (int n = 0; n < 200 && c < 0; n++) begin
      @(negedge clk);
      if (b1.resp_valid) c = cyc;
    end
    if (c < 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: resp_valid stayed 0, expected a response");
    end
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int n = 0; n < 200 && ok == 0; n++) begin
      @(negedge clk);
      if (!b1.busy) ok = 1;
    end
    if (ok == 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy stayed 1, expected IDLE");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input string name, input int pipe, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_data,
                      input logic exp_dbz, input bit bypass);
    int t;
    int c;
    int sc;
    sc = start_cnt;
    send(pipe, op, a, b, exp_data, exp_dbz, 1'b1, t);
    wait_valid(c);
    if (bypass) begin
      chk({name, "_lat"}, 64'(c), 64'(t + 1));
      chk({name, "_nostart"}, 64'(start_cnt), 64'(sc));
    end else begin
      chk({name, "_lat"}, 64'(c), 64'(t + 2 + lat));
      chk({name, "_start"}, 64'(last_start_cyc), 64'(t + 1));
    end
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  int t0, t1, t, c, hb, hs_before, n0, n1;
  logic [33:0] snap;

  initial begin
    checks = 0; errors = 0; start_cnt = 0; last_start_cyc = -1; hs_cnt = 0;
    lat = 8; rst = 1'b1;
    b1.flush = 1'b0; b1.resp_ready = 1'b1;
    set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
    b0.flush = 1'b0; b0.resp_ready = 1'b1;
    b0.req0_valid = 1'b0; b0.req0_op = 2'b00; b0.req0_a = 32'h0; b0.req0_b = 32'h0;
    b0.req1_valid = 1'b0; b0.req1_op = 2'b00; b0.req1_a = 32'h0; b0.req1_b = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_ctrl", 64'({b1.resp_valid, b1.busy, b1.div_start, b1.div_signed,
                           b1.resp_id, b1.resp_dbz, b1.req0_ready, b1.req1_ready}), 64'h0);
    chk("reset_ops", {b1.div_dividend, b1.div_divisor}, 64'h0);
    chk("reset_data", 64'(b1.resp_data), 64'h0);
    chk("reset_state", 64'(b1.dbg_state), 64'(S_IDLE));
    @(posedge clk);
    #1;

    // Tie straight out of reset: pipe 0 first, pipe 1 the cycle after the handshake.
    fork
      send(0, OP_DIV_WU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, t0);
      send(1, OP_MOD_WU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1, t1);
    join
    chk("tie_order", 64'(t1), 64'(t0 + 11));
    wait_idle();

    xact("divw", 0, OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    xact("modw", 0, OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    xact("divw_negb", 1, OP_DIV_W, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0);
    xact("modw_negb", 1, OP_MOD_W, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);
    lat = 1;
    xact("divwu_l1", 0, OP_DIV_WU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0, 1'b0);
    lat = 3;
    xact("modwu", 1, OP_MOD_WU, 32'hFFFF_FFF9, 32'd10, 32'd9, 1'b0, 1'b0);
    lat = 2;
    xact("divwu_min", 0, OP_DIV_WU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);

    xact("dbz_div", 1, OP_DIV_W, 32'd5, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    xact("dbz_mod", 1, OP_MOD_W, 32'd5, 32'h0, 32'd5, 1'b1, 1'b1);
    xact("dbz_divu", 0, OP_DIV_WU, 32'd7, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    xact("ovf_mod", 1, OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    xact("ovf_div", 0, OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);

    // Flush three cycles after div_start while pipe 1 waits: drain, then accept.
    lat = 8;
    send(0, OP_DIV_W, 32'd100, 32'd3, 32'h0, 1'b0, 1'b0, t);
    drain_bad = 0;
    drain_st = S_IDLE;
    fork
      send(1, OP_DIV_W, 32'd100, 32'd3, 32'd33, 1'b0, 1'b1, t1);
      begin
        repeat (3) @(posedge clk);
        #1 b1.flush = 1'b1;
        @(posedge clk);
        #1 b1.flush = 1'b0;
      end
      begin
        do begin
          @(negedge clk);
          if (b1.req1_ready || b1.resp_valid) drain_bad++;
          if (cyc == t + 5) drain_st = b1.dbg_state;
        end while (cyc < t + 9);
      end
    join
    chk("drain_block", 64'(drain_bad), 64'h0);
    chk("drain_state", 64'(drain_st), 64'(S_DRAIN));
    chk("drain_accept", 64'(t1), 64'(t + 10));
    wait_idle();

    // Response held with resp_ready low, then flush alongside resp_ready.
    b1.resp_ready = 1'b0;
    lat = 2;
    send(0, OP_DIV_WU, 32'd1000, 32'd10, 32'h0, 1'b0, 1'b0, t);
    wait_valid(c);
    chk("hold_lat", 64'(c), 64'(t + 4));
    snap = {b1.resp_id, b1.resp_dbz, b1.resp_data};
    chk("hold_data", 64'(snap), 64'({1'b0, 1'b0, 32'd100}));
    hb = 0;
    repeat (5) begin
      @(negedge clk);
      if (!b1.resp_valid || {b1.resp_id, b1.resp_dbz, b1.resp_data} !== snap) hb++;
    end
    chk("hold_stable", 64'(hb), 64'h0);
    hs_before = hs_cnt;
    @(posedge clk);
    #1 b1.resp_ready = 1'b1; b1.flush = 1'b1;
    @(negedge clk);
    chk("flush_resp_gated", 64'(b1.resp_valid), 64'h0);
    @(posedge clk);
    #1 b1.flush = 1'b0;
    @(negedge clk);
    chk("flush_no_hs", 64'(hs_cnt), 64'(hs_before));
    chk("flush_idle", 64'(b1.dbg_state), 64'(S_IDLE));
    @(posedge clk);
    #1;

    // Reset while WAITing: everything zero next cycle, then a clean transaction.
    lat = 8;
    send(1, OP_DIV_W, 32'd50, 32'd5, 32'h0, 1'b0, 1'b0, t);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_ctrl", 64'({b1.resp_valid, b1.busy, b1.div_start, b1.div_signed,
                              b1.resp_id, b1.resp_dbz, b1.req0_ready, b1.req1_ready}), 64'h0);
    chk("rst_wait_ops", {b1.div_dividend, b1.div_divisor}, 64'h0);
    chk("rst_wait_data", 64'(b1.resp_data), 64'h0);
    @(posedge clk);
    #1;
    lat = 4;
    xact("after_rst", 0, OP_DIV_W, 32'd50, 32'd5, 32'd10, 1'b0, 1'b0);

    // Fixed-priority instance: pipe 0 keeps re-requesting and wins every tie.
    b0.req0_valid = 1'b1; b0.req0_op = OP_DIV_W; b0.req0_a = 32'd1; b0.req0_b = 32'h0;
    b0.req1_valid = 1'b1; b0.req1_op = OP_DIV_W; b0.req1_a = 32'd2; b0.req1_b = 32'h0;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b0.req0_ready) n0++;
      if (b0.req1_ready) n1++;
      if (b0.resp_valid) chk("fp_resp", 64'({b0.resp_id, b0.resp_dbz, b0.resp_data}),
                             64'({1'b0, 1'b1, 32'hFFFF_FFFF}));
    end
    chk("fp_grants0", 64'(n0), 64'd3);
    chk("fp_grants1", 64'(n1), 64'd0);
    @(posedge clk);
    #1 b0.req0_valid = 1'b0; b0.req1_valid = 1'b0;

    repeat (4) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
